// File: rtl/nibble_word_queue_if.sv
// Bundle of enqueue, dequeue and overflow-status signals for the nibble word queue.
// The queue takes the slave view; the funnel/consumer side takes the master view.
interface nibble_word_queue_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  logic                       io_enq_valid;
  logic [WIDTH-1:0]           io_enq_bits;
  logic                       io_deq_ready;
  logic                       io_deq_valid;
  logic [WIDTH-1:0]           io_deq_bits;
  logic [$clog2(DEPTH):0]     io_count;
  logic                       io_overflow;
  logic [CNT_W-1:0]           io_drops;
  logic                       io_clear_overflow;

  modport slave (
    input  io_enq_valid, io_enq_bits, io_deq_ready, io_clear_overflow,
    output io_deq_valid, io_deq_bits, io_count, io_overflow, io_drops
  );

  modport master (
    output io_enq_valid, io_enq_bits, io_deq_ready, io_clear_overflow,
    input  io_deq_valid, io_deq_bits, io_count, io_overflow, io_drops
  );
endinterface

// File: rtl/nibble_word_queue.sv
// Small first-word-fall-through FIFO behind the backpressure-free nibble funnel.
// Words arriving while full are dropped and tallied in a sticky overflow flag and a saturating counter.
module nibble_word_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  nibble_word_queue_if.slave  q
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;
  logic [AW:0]      count;
  logic             overflow;
  logic [CNT_W-1:0] drops;

  logic full;
  logic deq;
  logic accept;
  logic drop;

  // A dequeue at full frees the slot the incoming word needs, so it is accepted.
  always_comb begin
    full   = (count == (AW+1)'(DEPTH));
    deq    = (count != '0) && q.io_deq_ready;
    accept = q.io_enq_valid && (!full || deq);
    drop   = q.io_enq_valid && full && !deq;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (deq)    rptr <= rptr + 1'b1;
      if (accept && !deq)      count <= count + 1'b1;
      else if (deq && !accept) count <= count - 1'b1;
    end
  end

  // Storage is deliberately left out of reset; only valid entries are ever observed.
  always_ff @(posedge clock) begin
    if (reset && accept) mem[wptr] <= q.io_enq_bits;
  end

  // A drop in the same cycle as a clear wins, leaving exactly one drop recorded.
  always_ff @(posedge clock) begin
    if (!reset) begin
      overflow <= 1'b0;
      drops    <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (q.io_clear_overflow) drops <= CNT_W'(1);
      else if (drops != '1)    drops <= drops + 1'b1;
    end else if (q.io_clear_overflow) begin
      overflow <= 1'b0;
      drops    <= '0;
    end
  end

  assign q.io_deq_valid = (count != '0);
  assign q.io_deq_bits  = mem[rptr];
  assign q.io_count     = count;
  assign q.io_overflow  = overflow;
  assign q.io_drops     = drops;
endmodule

// File: tb/tb_nibble_word_queue.sv
// Directed self-checking bench for nibble_word_queue (DEPTH=4, CNT_W=2 so drop saturation is reachable).
module tb_nibble_word_queue;
  localparam int WIDTH = 64;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;

  logic clock;
  logic reset;
  int   total;
  int   bad;

  nibble_word_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) q ();

  nibble_word_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock (clock),
    .reset (reset),
    .q     (q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are read at the same point.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic enq, input logic [63:0] bits, input logic ready, input logic clr);
    q.io_enq_valid      = enq;
    q.io_enq_bits       = bits;
    q.io_deq_ready      = ready;
    q.io_clear_overflow = clr;
    step();
    q.io_enq_valid      = 1'b0;
    q.io_deq_ready      = 1'b0;
    q.io_clear_overflow = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic valid, input int cnt, input logic ovf, input int drp);
    checkOutput({tag, "_valid"}, 64'(q.io_deq_valid), 64'(valid));
    checkOutput({tag, "_count"}, 64'(q.io_count), 64'(cnt));
    checkOutput({tag, "_overflow"}, 64'(q.io_overflow), 64'(ovf));
    checkOutput({tag, "_drops"}, 64'(q.io_drops), 64'(drp));
  endtask

  initial begin
    logic [63:0] drain_order [4];
    total = 0;
    bad   = 0;
    reset = 1'b0;
    q.io_enq_valid      = 1'b0;
    q.io_enq_bits       = '0;
    q.io_deq_ready      = 1'b0;
    q.io_clear_overflow = 1'b0;
    #1;

    // Reset held for two edges, then released.
    step();
    step();
    reset = 1'b1;
    check_status("reset", 1'b0, 0, 1'b0, 0);

    // Single word: no same-cycle bypass, visible one cycle later, then consumed.
    q.io_enq_valid = 1'b1;
    q.io_enq_bits  = 64'h0123456789ABCDEF;
    #1;
    checkOutput("no_bypass_valid", 64'(q.io_deq_valid), 64'd0);
    applyStimulus(1'b1, 64'h0123456789ABCDEF, 1'b0, 1'b0);
    checkOutput("single_valid", 64'(q.io_deq_valid), 64'd1);
    checkOutput("single_bits", q.io_deq_bits, 64'h0123456789ABCDEF);
    checkOutput("single_count", 64'(q.io_count), 64'd1);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
    checkOutput("single_drained_count", 64'(q.io_count), 64'd0);
    checkOutput("single_drained_valid", 64'(q.io_deq_valid), 64'd0);

    // Empty FIFO ignores deq_ready.
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
    checkOutput("underflow_count", 64'(q.io_count), 64'd0);

    // Fill with 1..4, word 5 dropped, drain in order.
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 64'(i), 1'b0, 1'b0);
    checkOutput("full_count", 64'(q.io_count), 64'd4);
    applyStimulus(1'b1, 64'd5, 1'b0, 1'b0);
    check_status("drop1", 1'b1, 4, 1'b1, 1);
    for (int i = 1; i <= 4; i++) begin
      checkOutput($sformatf("drain_a%0d", i), q.io_deq_bits, 64'(i));
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
    end
    checkOutput("drain_a_count", 64'(q.io_count), 64'd0);

    // Full plus simultaneous enq and deq: word 6 accepted, no drop.
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 64'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 64'd6, 1'b1, 1'b0);
    check_status("enq_deq_full", 1'b1, 4, 1'b1, 1);
    drain_order[0] = 64'd2;
    drain_order[1] = 64'd3;
    drain_order[2] = 64'd4;
    drain_order[3] = 64'd6;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain_b%0d", i), q.io_deq_bits, drain_order[i]);
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
    end
    checkOutput("drain_b_valid", 64'(q.io_deq_valid), 64'd0);

    // Drop saturation at 3, clear racing a drop, then clear alone.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 64'h10 + 64'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 64'hE0 + 64'(i), 1'b0, 1'b0);
    checkOutput("drops_at_4", 64'(q.io_drops), 64'd3);
    applyStimulus(1'b1, 64'hE4, 1'b0, 1'b0);
    check_status("sat", 1'b1, 4, 1'b1, 3);
    checkOutput("sat_head_kept", q.io_deq_bits, 64'h10);
    applyStimulus(1'b1, 64'hE5, 1'b0, 1'b1);
    check_status("clear_with_drop", 1'b1, 4, 1'b1, 1);
    applyStimulus(1'b0, 64'd0, 1'b0, 1'b1);
    check_status("clear_alone", 1'b1, 4, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain_c%0d", i), q.io_deq_bits, 64'h10 + 64'(i));
      applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
    end

    // Mid-stream reset during a dequeue discards everything.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 64'h21 + 64'(i), 1'b0, 1'b0);
    checkOutput("load3_count", 64'(q.io_count), 64'd3);
    reset = 1'b0;
    applyStimulus(1'b0, 64'd0, 1'b1, 1'b0);
    reset = 1'b1;
    check_status("midreset", 1'b0, 0, 1'b0, 0);
    applyStimulus(1'b1, 64'hAA, 1'b0, 1'b0);
    checkOutput("post_reset_valid", 64'(q.io_deq_valid), 64'd1);
    checkOutput("post_reset_bits", q.io_deq_bits, 64'hAA);
    checkOutput("post_reset_count", 64'(q.io_count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nibble_word_queue.md
Name: nibble_word_queue

Overview:
- Buffers 64-bit words from the nibble funnel and hands them to the downstream consumer.
- The funnel's output has no backpressure: it presents one valid word for one cycle.
- This block stores those words in a small FIFO, which gives the downstream side a proper ready/valid handshake.
- Words that arrive while the FIFO is full are dropped; each drop is counted and latched into a sticky overflow flag.

Parameters:
- WIDTH, 64: word width in bits; matches the funnel output.
- DEPTH, 4: FIFO entries; must be a power of 2, ≥2.
- CNT_W, 8: width of the saturating drop counter.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 resets on the next rising clock edge).
- io_enq_valid  input  1  word present this cycle; there is no ready to the producer.
- io_enq_bits  input  WIDTH  word data.
- io_deq_ready  input  1  consumer accepts the head word.
- io_deq_valid  output  1  FIFO not empty.
- io_deq_bits  output  WIDTH  head entry data; first-word-fall-through.
- io_count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- io_overflow  output  1  sticky flag: at least one word has been dropped.
- io_drops  output  CNT_W  number of dropped words; saturates.
- io_clear_overflow  input  1  clears io_overflow and io_drops.

Behaviour:
- Reset (reset==0 at a clock edge):
  - Read pointer, write pointer, count, io_overflow and io_drops all go to 0.
  - io_deq_valid=0 and io_count=0 from the following cycle.
  - Storage RAM is not reset; io_deq_bits is don't-care while io_deq_valid=0.
  - Reset overrides every other input in the same cycle; a mid-stream reset discards all buffered words.
- Handshake events:
  - enq = io_enq_valid.
  - deq = io_deq_valid & io_deq_ready.
  - io_deq_valid does not depend combinationally on io_deq_ready.
- Full and empty:
  - io_deq_valid = (count != 0).
  - full = (count == DEPTH).
- Accept rule:
  - A word is accepted iff enq & (!full | deq).
  - At full, a simultaneous deq frees a slot, so the incoming word is accepted and count stays at DEPTH.
- Write on accept: mem[wptr] <= io_enq_bits; wptr increments modulo DEPTH.
- Read on deq: rptr increments modulo DEPTH.
- Count update: +1 on accept without deq; -1 on deq without accept; unchanged when both or neither occur.
- Latency and ordering:
  - A word enqueued into an empty FIFO in cycle N appears with io_deq_valid=1 in cycle N+1. There is no same-cycle bypass.
  - Words leave in arrival order.
  - Pointers wrap silently; DEPTH consecutive enqueues followed by DEPTH dequeues return the words in order.
- Drop rule:
  - A drop occurs when enq & full & !deq.
  - The word is discarded and the FIFO contents are unchanged.
  - io_drops increments by 1 and saturates at 2^CNT_W-1 (no wrap).
  - io_overflow sets to 1.
- Clear:
  - io_clear_overflow=1 sets io_overflow=0 and io_drops=0 on the next edge.
  - If a drop occurs in the same cycle as a clear, the drop wins: io_overflow=1 and io_drops=1.
- Fault tolerance: io_deq_ready=1 while empty has no effect (no underflow, no pointer movement).
- Implementation limits:
  - All outputs come from registers or the storage array; no combinational path from an input to io_deq_valid.
  - The only combinational input-to-output path is the mux from the rptr-selected entry to io_deq_bits.

Test Plan:
- Reset with reset=0 for 2 cycles, then release -> io_deq_valid=0, io_count=0, io_overflow=0, io_drops=0.
- Enqueue 64'h0123456789ABCDEF in cycle N with io_deq_ready=0 -> cycle N+1: io_deq_valid=1, io_deq_bits=64'h0123456789ABCDEF, io_count=1. Then set io_deq_ready=1 for 1 cycle -> io_count=0, io_deq_valid=0.
- Fill with 4 words 1,2,3,4, then enqueue word 5 with io_deq_ready=0 -> word 5 dropped, io_count=4, io_overflow=1, io_drops=1. Drain -> outputs 1,2,3,4 in order.
- FIFO full, enqueue word 6 with io_deq_ready=1 in the same cycle -> word 1 dequeued, word 6 accepted, io_count stays 4, io_drops unchanged. Drain order: 2,3,4,6.
- Drop saturation and clear (CNT_W=2):
  - Produce 5 drops while full -> io_drops=3.
  - Assert io_clear_overflow together with a sixth drop -> io_overflow=1, io_drops=1.
  - Assert io_clear_overflow alone -> io_overflow=0, io_drops=0.
- Load 3 words, assert reset=0 for 1 cycle during a deq -> io_count=0 and io_deq_valid=0 next cycle. A subsequent enqueue of 64'hAA is the first word out.
